// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader that fills instruction RAM and gates core reset
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begins a load session when not busy
//   byte_valid/byte_data input byte stream, handshaked with byte_ready
//   mem_we/addr/wdata    one-cycle write strobe, address and 16-bit word to instruction RAM
//   cpu_rst              holds the core in reset unless the last load completed cleanly
//   busy, done, error    session in progress, last load good (sticky), last load failed (sticky)
module imem_loader #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LEN_HI  = 3'd1;
  localparam logic [2:0] LEN_LO  = 3'd2;
  localparam logic [2:0] DATA_HI = 3'd3;
  localparam logic [2:0] DATA_LO = 3'd4;
  localparam logic [2:0] CSUM    = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;
  localparam logic [2:0] ERROR   = 3'd7;
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;
  logic [2:0]      state;
  logic [7:0]      len_hi;
  logic [7:0]      hi;
  logic [7:0]      csum;
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] wcnt;
  logic [15:0]     n;
  logic            xfer;
  logic            bad_len;
  assign byte_ready = state >= LEN_HI && state <= CSUM;
  assign busy       = byte_ready;
  assign done       = state == DONE;
  assign error      = state == ERROR;
  assign cpu_rst    = state != DONE;
  assign xfer       = byte_valid && byte_ready;
  assign n          = {len_hi, byte_data};
  assign bad_len    = n == 16'd0 || {1'b0, n} > MAX_N;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_hi    <= '0;
      hi        <= '0;
      csum      <= '0;
      len       <= '0;
      wcnt      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      // saturate so the final word of a full-capacity load leaves the address at the top
      if (mem_we && mem_addr != '1) mem_addr <= mem_addr + ADDR_W'(1);
      case (state)
        IDLE, DONE, ERROR: if (start) begin
          state    <= LEN_HI;
          mem_addr <= '0;
          wcnt     <= '0;
          csum     <= '0;
        end
        LEN_HI: if (xfer) begin
          len_hi <= byte_data;
          state  <= LEN_LO;
        end
        LEN_LO: if (xfer) begin
          len   <= n[ADDR_W:0];
          state <= bad_len ? ERROR : DATA_HI;
        end
        DATA_HI: if (xfer) begin
          hi    <= byte_data;
          csum  <= csum ^ byte_data;
          state <= DATA_LO;
        end
        DATA_LO: if (xfer) begin
          mem_we    <= 1'b1;
          mem_wdata <= {hi, byte_data};
          csum      <= csum ^ byte_data;
          wcnt      <= wcnt + (ADDR_W+1)'(1);
          state     <= wcnt + (ADDR_W+1)'(1) == len ? CSUM : DATA_HI;
        end
        CSUM: if (xfer) state <= byte_data == csum ? DONE : ERROR;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a stream-level model
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;
  int pass = 0;
  int total = 0;
  logic [26:0] wq[$];

  imem_loader #(.ADDR_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});

  // stream = length header, hi/lo payload bytes, XOR of payload; expected writes are (index, word)
  function automatic void build(input logic [15:0] w[$], input bit bad,
                                output logic [7:0] s[$], output logic [26:0] e[$]);
    logic [7:0] x = 8'h00;
    s = {};
    e = {};
    s.push_back(8'(w.size() >> 8));
    s.push_back(8'(w.size()));
    foreach (w[i]) begin
      s.push_back(w[i][15:8]);
      s.push_back(w[i][7:0]);
      x ^= w[i][15:8] ^ w[i][7:0];
      e.push_back({11'(i), w[i]});
    end
    s.push_back(bad ? x ^ 8'h01 : x);
  endfunction

  // mode 0: full rate, 1: valid every other cycle, 2: random valid; start raised while byte pulse_at is offered
  task automatic send(input logic [7:0] s[$], input int mode, input int pulse_at);
    int i = 0;
    int stall = 0;
    bit tog = 1'b0;
    while (i < s.size()) begin
      @(negedge clk);
      tog = ~tog;
      byte_valid = mode == 0 ? 1'b1 : mode == 1 ? tog : 1'($urandom % 2);
      byte_data = byte_valid ? s[i] : 8'($urandom);
      start = i == pulse_at;
      if (byte_valid && byte_ready) begin
        i++;
        stall = 0;
      end else if (++stall > 100) begin
        total++;
        $display("FAIL send_timeout byte %0d ready=%b required 1", i, byte_ready);
        break;
      end
      @(posedge clk);
    end
    #1;
    byte_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    wq = {};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, byte_ready} !== 2'b11) $display("FAIL start_busy got %b required 11", {busy, byte_ready});
    else pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if ({byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, error} !== {2'b00, 11'd0, 16'd0, 4'b1000})
      $display("FAIL reset_values got %b required %b", {byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, error},
               {2'b00, 11'd0, 16'd0, 4'b1000});
    else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic session(input string name, input logic [15:0] w[$], input bit bad, input int mode, input int pulse_at);
    logic [7:0] s[$];
    logic [26:0] e[$];
    bit ok;
    build(w, bad, s, e);
    do_start();
    send(s, mode, pulse_at);
    @(negedge clk);
    total++;
    if ({done, error, busy, cpu_rst} !== {~bad, bad, 1'b0, bad})
      $display("FAIL %s_flags done/error/busy/cpu_rst got %b required %b", name, {done, error, busy, cpu_rst}, {~bad, bad, 1'b0, bad});
    else pass++;
    @(negedge clk);
    ok = wq.size() == e.size();
    foreach (e[i]) if (ok && wq[i] !== e[i]) ok = 1'b0;
    total++;
    if (!ok) $display("FAIL %s_writes got %0d writes (first %h) required %0d (first %h)", name, wq.size(),
                      wq.size() > 0 ? wq[0] : 27'h0, e.size(), e[0]);
    else pass++;
  endtask

  task automatic test_good_load();
    session("good", '{16'h0123, 16'h4567, 16'h89AB}, 1'b0, 0, -1);
  endtask

  task automatic test_bad_csum();
    session("bad_csum", '{16'h0123, 16'h4567, 16'h89AB}, 1'b1, 0, -1);
    session("retry", '{16'h0123, 16'h4567, 16'h89AB}, 1'b0, 0, -1);
  endtask

  task automatic test_bad_len();
    logic [15:0] hdr[3];
    hdr[0] = 16'h0000;
    hdr[1] = 16'h0801;
    hdr[2] = 16'($urandom_range(2049, 65535));
    for (int k = 0; k < 3; k++) begin
      do_start();
      send('{hdr[k][15:8], hdr[k][7:0]}, 0, -1);
      @(negedge clk);
      total++;
      if ({error, done, byte_ready, busy} !== 4'b1000)
        $display("FAIL bad_len_%h error/done/ready/busy got %b required 1000", hdr[k], {error, done, byte_ready, busy});
      else pass++;
      repeat (3) @(negedge clk);
      total++;
      if (wq.size() != 0) $display("FAIL bad_len_%h_writes got %0d required 0", hdr[k], wq.size());
      else pass++;
    end
  endtask

  task automatic test_stall();
    session("stall", '{16'h0123, 16'h4567, 16'h89AB}, 1'b0, 1, 4);
  endtask

  task automatic test_random();
    logic [15:0] w[$];
    for (int k = 0; k < 6; k++) begin
      w = {};
      repeat ($urandom_range(1, 40)) w.push_back(16'($urandom));
      session("random", w, 1'($urandom_range(0, 2) == 0), 2, $urandom_range(0, 10));
    end
  endtask

  task automatic test_max_load();
    logic [15:0] w[$];
    for (int i = 0; i < 2048; i++) w.push_back(16'(i));
    session("max", w, 1'b0, 0, -1);
    total++;
    if ({wq[$], mem_addr} !== {11'd2047, 16'h07FF, 11'd2047})
      $display("FAIL max_last_write got %h addr_after %0d required %h addr_after 2047", wq[$], mem_addr, {11'd2047, 16'h07FF});
    else pass++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] w[$];
    logic [7:0] s[$];
    logic [26:0] e[$];
    bit ok;
    for (int i = 0; i < 32; i++) w.push_back(16'($urandom));
    build(w, 1'b0, s, e);
    do_start();
    send(s[0:21], 0, -1);
    total++;
    if (mem_we !== 1'b1) $display("FAIL mid_pending_we got %b required 1", mem_we);
    else pass++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, error} !== {2'b00, 11'd0, 16'd0, 4'b1000})
      $display("FAIL mid_reset_values got %b required %b", {byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, error},
               {2'b00, 11'd0, 16'd0, 4'b1000});
    else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    ok = wq.size() == 9;
    for (int i = 0; i < 9; i++) if (ok && wq[i] !== e[i]) ok = 1'b0;
    total++;
    if (!ok) $display("FAIL mid_writes got %0d writes required 9 matching", wq.size());
    else pass++;
    total++;
    if ({busy, byte_ready, done, error, cpu_rst} !== 5'b00001)
      $display("FAIL mid_idle busy/ready/done/error/cpu_rst got %b required 00001", {busy, byte_ready, done, error, cpu_rst});
    else pass++;
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_csum();
    test_bad_len();
    test_stall();
    test_random();
    test_max_load();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
